pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Program-counter controller for the simple CPU front end.
- Owns the PC register and sequences the PC-increment datapath (pc + AMOUNT, modulo 2^SIZE).
- Issues instruction fetches to memory over a req/ack handshake.
- Hands fetched words to the decoder over a valid/ready handshake, and applies jumps and halts.

Parameters:
- SIZE, 16, width of PC, addresses and instruction words.
- AMOUNT, 1, PC increment per fetched instruction.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  run permission; when low, the block idles after the current instruction is issued.
- jump_valid  input  1  one-cycle jump request.
- jump_addr  input  SIZE  jump target, sampled when jump_valid=1.
- halt  input  1  stop request, sampled on an instruction handoff.
- mem_req  output  1  fetch request to memory.
- mem_addr  output  SIZE  fetch address; always equals pc.
- mem_ack  input  1  memory completion; mem_data is valid in this cycle.
- mem_data  input  SIZE  fetched instruction word.
- instr_valid  output  1  instruction available to the decoder.
- instr_data  output  SIZE  registered instruction word.
- instr_pc  output  SIZE  address the instruction was fetched from.
- instr_ready  input  1  decoder accepts the instruction.
- pc  output  SIZE  current PC register.
- halted  output  1  high in the HALTED state.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, mem_req=0, instr_valid=0, instr_data=0, instr_pc=0, halted=0. Reset applies immediately mid-fetch or mid-handoff; any outstanding ack arriving after release is ignored.
- States: IDLE, FETCH, ISSUE, HALTED. All outputs are registered or decoded directly from state. mem_req=1 only in FETCH; instr_valid=1 only in ISSUE.
- IDLE:
  - jump_valid=1 -> pc<=jump_addr; stays IDLE unless enable.
  - enable=1 -> FETCH next cycle; mem_req rises 1 cycle after enable is seen.
- FETCH:
  - mem_req=1 and mem_addr=pc, held stable until mem_ack.
  - mem_ack=1, jump_valid=0 -> instr_data<=mem_data, instr_pc<=pc, pc<=pc+AMOUNT (truncated to SIZE, wraps at 2^SIZE-1), go to ISSUE.
  - jump_valid=1 (with or without mem_ack) -> fetched data discarded, pc<=jump_addr, mem_req deasserts for exactly 1 cycle (pending request closed), then re-enters FETCH at the new address.
  - mem_ack arriving without mem_req is ignored.
- ISSUE:
  - instr_valid=1; instr_data and instr_pc are held stable until instr_ready.
  - On instr_ready=1, priority order:
    1. jump_valid -> pc<=jump_addr, then FETCH.
    2. halt -> HALTED.
    3. enable -> FETCH.
    4. Otherwise -> IDLE.
  - jump_valid=1 with instr_ready=0 -> pending instruction flushed (instr_valid drops next cycle), pc<=jump_addr, go to FETCH.
  - halt is ignored when instr_ready=0.
- HALTED: halted=1, mem_req=0, instr_valid=0. jump_valid and enable are ignored. Exits only via rst_n.
- Minimum throughput: 2 cycles per instruction (FETCH with ack on its first cycle, ISSUE with ready on its first cycle).
- pc+AMOUNT is computed at SIZE bits and the carry is discarded.

Test Plan:
- Reset, enable=1, memory acks every request in the same cycle, ready always 1 -> mem_addr sequence 0,1,2,3; instr_pc 0,1,2 on consecutive ISSUE cycles; 2 cycles per instruction.
- RESET_PC=16'hFFFF, one fetch -> instr_pc=FFFF, pc=0000 after the ack (wrap-around).
- Memory ack delayed 3 cycles -> mem_req stays high with mem_addr constant for 4 cycles; one instruction issued.
- Decoder holds instr_ready=0 for 5 cycles -> instr_valid, instr_data and instr_pc stable; no new mem_req.
- jump_valid with jump_addr=16'h0040 in the same cycle as mem_ack (pc=5) -> data dropped, mem_req low for 1 cycle, next mem_addr=0040, no instruction issued for address 5.
- halt=1 with instr_ready=1 -> halted=1 and no further mem_req regardless of enable/jump; rst_n pulse mid-FETCH -> pc=RESET_PC and mem_req=0 asynchronously.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the program counter, fetches instruction words
// from memory over a req/ack handshake and hands them to the decoder over a
// valid/ready handshake. Jumps redirect the PC; halt parks the block until reset.
module pc_fetch_sequencer #(
  parameter int unsigned     SIZE     = 16,
  parameter int unsigned     AMOUNT   = 1,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            jump_valid,
  input  logic [SIZE-1:0] jump_addr,
  input  logic            halt,
  output logic            mem_req,
  output logic [SIZE-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [SIZE-1:0] mem_data,
  output logic            instr_valid,
  output logic [SIZE-1:0] instr_data,
  output logic [SIZE-1:0] instr_pc,
  input  logic            instr_ready,
  output logic [SIZE-1:0] pc,
  output logic            halted
);

  // PC step truncated to the PC width so the add wraps with the carry dropped
  localparam logic [SIZE-1:0] STEP = SIZE'(AMOUNT);

  // ST_REDIRECT is the single request-free cycle that closes an outstanding
  // fetch after a jump, so a late ack for the old address cannot be taken
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REDIRECT,
    ST_ISSUE,
    ST_HALTED
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [SIZE-1:0] pc_next;
  logic            capture;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, next-PC and instruction-capture decisions
  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (jump_valid) begin
          pc_next = jump_addr;
        end
        if (enable) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (jump_valid) begin
          pc_next    = jump_addr;
          state_next = ST_REDIRECT;
        end else if (mem_ack) begin
          capture    = 1'b1;
          pc_next    = pc + STEP;
          state_next = ST_ISSUE;
        end
      end
      ST_REDIRECT: begin
        state_next = ST_FETCH;
      end
      ST_ISSUE: begin
        if (jump_valid) begin
          pc_next    = jump_addr;
          state_next = ST_FETCH;
        end else if (instr_ready) begin
          if (halt) begin
            state_next = ST_HALTED;
          end else if (enable) begin
            state_next = ST_FETCH;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // PC and captured instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      instr_data <= '0;
      instr_pc   <= '0;
    end else begin
      pc <= pc_next;
      if (capture) begin
        instr_data <= mem_data;
        instr_pc   <= pc;
      end
    end
  end

  assign mem_req     = (state == ST_FETCH);
  assign instr_valid = (state == ST_ISSUE);
  assign halted      = (state == ST_HALTED);
  assign mem_addr    = pc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus a
// randomized run checked against a phase-level reference model.
module tb_pc_fetch_sequencer;

  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_ISSUE = 2;
  localparam int PH_GAP   = 3;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        jump_valid;
  logic [15:0] jump_addr;
  logic        halt;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [15:0] pc;
  logic        halted;

  logic        w_mem_req;
  logic [15:0] w_mem_addr;
  logic        w_instr_valid;
  logic [15:0] w_instr_data;
  logic [15:0] w_instr_pc;
  logic [15:0] w_pc;
  logic        w_halted;

  int checks = 0;
  int errors = 0;

  pc_fetch_sequencer #(.SIZE(16), .AMOUNT(1), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .jump_valid(jump_valid),
    .jump_addr(jump_addr), .halt(halt), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .instr_valid(instr_valid),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .pc(pc), .halted(halted)
  );

  pc_fetch_sequencer #(.SIZE(16), .AMOUNT(1), .RESET_PC(16'hFFFF)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .jump_valid(jump_valid),
    .jump_addr(jump_addr), .halt(halt), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .instr_valid(w_instr_valid),
    .instr_data(w_instr_data), .instr_pc(w_instr_pc), .instr_ready(instr_ready),
    .pc(w_pc), .halted(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a fixed function of address
  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [15:0] r;
    r = a * 16'h9E37;
    return r ^ 16'h5A5A;
  endfunction

  task automatic tick();
    @(negedge clk);
    mem_data = memf(mem_addr);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    jump_valid  = 1'b0;
    jump_addr   = 16'h0000;
    halt        = 1'b0;
    mem_ack     = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    mem_data = memf(mem_addr);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_req, instr_valid, halted} !== 3'b000 || pc !== 16'h0000 ||
        instr_data !== 16'h0000 || instr_pc !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_state: got req=%b vld=%b hlt=%b pc=%h data=%h ipc=%h, expected all zero",
               mem_req, instr_valid, halted, pc, instr_data, instr_pc);
    end
    checks++;
    if (w_pc !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL reset_pc_param: got %h, expected ffff", w_pc);
    end
  endtask

  task automatic test_stream();
    logic [15:0] a;
    do_reset();
    enable = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_idle_req: got %b, expected 0", mem_req);
    end
    for (int k = 0; k < 7; k++) begin
      tick();
      a = 16'(k / 2);
      checks++;
      if (k % 2 == 0) begin
        if (mem_req !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== a) begin
          errors++;
          $display("[TB] FAIL stream_fetch%0d: got req=%b vld=%b addr=%h, expected req=1 vld=0 addr=%h",
                   k, mem_req, instr_valid, mem_addr, a);
        end
      end else begin
        if (instr_valid !== 1'b1 || mem_req !== 1'b0 || instr_pc !== a || instr_data !== memf(a)) begin
          errors++;
          $display("[TB] FAIL stream_issue%0d: got vld=%b req=%b ipc=%h data=%h, expected vld=1 req=0 ipc=%h data=%h",
                   k, instr_valid, mem_req, instr_pc, instr_data, a, memf(a));
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    enable = 1'b1; mem_ack = 1'b1; instr_ready = 1'b0;
    tick();
    checks++;
    if (w_mem_req !== 1'b1 || w_mem_addr !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL wrap_fetch: got req=%b addr=%h, expected req=1 addr=ffff", w_mem_req, w_mem_addr);
    end
    tick();
    checks++;
    if (w_instr_valid !== 1'b1 || w_instr_pc !== 16'hFFFF || w_pc !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL wrap_issue: got vld=%b ipc=%h pc=%h, expected vld=1 ipc=ffff pc=0000",
               w_instr_valid, w_instr_pc, w_pc);
    end
  endtask

  task automatic test_ack_delay();
    do_reset();
    enable = 1'b1; mem_ack = 1'b0; instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_ack = (k == 3);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ack_delay_hold%0d: got req=%b addr=%h vld=%b, expected req=1 addr=0000 vld=0",
                 k, mem_req, mem_addr, instr_valid);
      end
    end
    tick();
    mem_ack = 1'b0; enable = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== memf(16'h0000) || pc !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL ack_delay_issue: got vld=%b ipc=%h data=%h pc=%h, expected vld=1 ipc=0000 data=%h pc=0001",
               instr_valid, instr_pc, instr_data, pc, memf(16'h0000));
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_delay_idle: got vld=%b req=%b, expected 0 0", instr_valid, mem_req);
    end
  endtask

  task automatic test_stall();
    logic [15:0] d0;
    do_reset();
    enable = 1'b1; mem_ack = 1'b1; instr_ready = 1'b0;
    tick();
    tick();
    d0 = memf(16'h0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_data !== d0 || instr_pc !== 16'h0000 || mem_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got vld=%b data=%h ipc=%h req=%b, expected vld=1 data=%h ipc=0000 req=0",
                 k, instr_valid, instr_data, instr_pc, mem_req, d0);
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL stall_release: got req=%b addr=%h, expected req=1 addr=0001", mem_req, mem_addr);
    end
  endtask

  task automatic test_jump_on_ack();
    do_reset();
    jump_valid = 1'b1; jump_addr = 16'h0005;
    tick();
    checks++;
    if (pc !== 16'h0005 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_jump: got pc=%h req=%b, expected pc=0005 req=0", pc, mem_req);
    end
    jump_valid = 1'b0; enable = 1'b1; instr_ready = 1'b1;
    tick();
    mem_ack = 1'b1; jump_valid = 1'b1; jump_addr = 16'h0040;
    tick();
    jump_valid = 1'b0; mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0040) begin
      errors++;
      $display("[TB] FAIL jump_gap: got req=%b vld=%b pc=%h, expected req=0 vld=0 pc=0040", mem_req, instr_valid, pc);
    end
    tick();
    mem_ack = 1'b1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jump_refetch: got req=%b addr=%h vld=%b, expected req=1 addr=0040 vld=0",
               mem_req, mem_addr, instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0040) begin
      errors++;
      $display("[TB] FAIL jump_issue: got vld=%b ipc=%h, expected vld=1 ipc=0040", instr_valid, instr_pc);
    end
  endtask

  task automatic test_priority();
    do_reset();
    enable = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1;
    tick();
    tick();
    halt = 1'b1; jump_valid = 1'b1; jump_addr = 16'h0200;
    tick();
    halt = 1'b0; jump_valid = 1'b0;
    checks++;
    if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0200) begin
      errors++;
      $display("[TB] FAIL jump_over_halt: got hlt=%b req=%b addr=%h, expected hlt=0 req=1 addr=0200",
               halted, mem_req, mem_addr);
    end
  endtask

  task automatic test_halt();
    do_reset();
    enable = 1'b1; mem_ack = 1'b1; instr_ready = 1'b0; halt = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (instr_valid !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_needs_ready: got vld=%b hlt=%b, expected vld=1 hlt=0", instr_valid, halted);
    end
    instr_ready = 1'b1;
    tick();
    halt = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0001) begin
        errors++;
        $display("[TB] FAIL halted%0d: got hlt=%b req=%b vld=%b pc=%h, expected hlt=1 req=0 vld=0 pc=0001",
                 k, halted, mem_req, instr_valid, pc);
      end
      jump_valid = 1'($urandom_range(0, 1));
      jump_addr  = 16'($urandom);
      tick();
    end
    jump_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    jump_valid = 1'b1; jump_addr = 16'h0123; enable = 1'b1;
    tick();
    jump_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 16'h0000 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got pc=%h req=%b, expected pc=0000 req=0", pc, mem_req);
    end
    mem_ack = 1'b1; enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL stale_ack: got req=%b vld=%b pc=%h, expected req=0 vld=0 pc=0000",
               mem_req, instr_valid, pc);
    end
    mem_ack = 1'b0;
  endtask

  // Randomized run: the model tracks only which phase the block should be in,
  // the next fetch address and the address of the instruction on offer
  task automatic test_random();
    int          phase;
    logic [15:0] exp_addr;
    logic [15:0] issue_pc;
    do_reset();
    phase    = PH_IDLE;
    exp_addr = 16'h0000;
    issue_pc = 16'h0000;
    for (int n = 0; n < 600; n++) begin
      checks++;
      if (pc !== exp_addr || mem_addr !== exp_addr) begin
        errors++;
        $display("[TB] FAIL rand_pc%0d: got pc=%h addr=%h, expected %h", n, pc, mem_addr, exp_addr);
      end
      checks++;
      case (phase)
        PH_FETCH: begin
          if (mem_req !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_fetch%0d: got req=%b vld=%b, expected req=1 vld=0", n, mem_req, instr_valid);
          end
        end
        PH_ISSUE: begin
          if (instr_valid !== 1'b1 || mem_req !== 1'b0 || instr_pc !== issue_pc || instr_data !== memf(issue_pc)) begin
            errors++;
            $display("[TB] FAIL rand_issue%0d: got vld=%b req=%b ipc=%h data=%h, expected vld=1 req=0 ipc=%h data=%h",
                     n, instr_valid, mem_req, instr_pc, instr_data, issue_pc, memf(issue_pc));
          end
        end
        default: begin
          if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_quiet%0d: got req=%b vld=%b, expected 0 0", n, mem_req, instr_valid);
          end
        end
      endcase

      enable      = ($urandom_range(0, 99) < 85);
      mem_ack     = ($urandom_range(0, 99) < 40);
      instr_ready = ($urandom_range(0, 1) == 1);
      jump_valid  = (phase != PH_GAP) && ($urandom_range(0, 7) == 0);
      jump_addr   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);

      case (phase)
        PH_IDLE: begin
          if (jump_valid) exp_addr = jump_addr;
          phase = enable ? PH_FETCH : PH_IDLE;
        end
        PH_FETCH: begin
          if (jump_valid) begin
            exp_addr = jump_addr;
            phase    = PH_GAP;
          end else if (mem_ack) begin
            issue_pc = exp_addr;
            exp_addr = exp_addr + 16'd1;
            phase    = PH_ISSUE;
          end
        end
        PH_ISSUE: begin
          if (jump_valid) begin
            exp_addr = jump_addr;
            phase    = PH_FETCH;
          end else if (instr_ready) begin
            phase = enable ? PH_FETCH : PH_IDLE;
          end
        end
        default: begin
          phase = PH_FETCH;
        end
      endcase
      tick();
    end
    jump_valid = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; jump_valid = 1'b0; jump_addr = 16'h0000;
    halt = 1'b0; mem_ack = 1'b0; mem_data = 16'h0000; instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_wrap();
    test_ack_delay();
    test_stall();
    test_jump_on_ack();
    test_priority();
    test_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
